// File: rtl/ctrl_ramwr_pkg.sv
// ctrl_ramwr shared definitions.
// Sizes and FSM state encodings for the RAM write-side driver.
package ctrl_ramwr_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef enum logic {
        CTRL_RAMWR_IDLE = 1'b0,
        CTRL_RAMWR_COEF = 1'b1
    } state_t;

endpackage

// File: rtl/ctrl_ramwr_if.sv
// ctrl_ramwr bus bundle.
// Sample stream, CPU coefficient port, RAM port A and status.
interface ctrl_ramwr_if
    import ctrl_ramwr_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W
);

    logic                  seg_init;
    logic [ADDR_WIDTH-1:0] data_bptr;
    logic [ADDR_WIDTH-1:0] data_lptr;
    logic                  calc_busy;
    logic                  smp_valid;
    logic [DATA_WIDTH-1:0] smp_data;
    logic                  smp_ready;
    logic                  coef_start;
    logic [ADDR_WIDTH-1:0] coef_ptr;
    logic [ADDR_WIDTH-1:0] coef_len;
    logic                  coef_valid;
    logic [DATA_WIDTH-1:0] coef_data;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [ADDR_WIDTH-1:0] data_hptr;
    logic                  new_smp;
    logic                  buf_full;
    logic                  coef_done;

    modport master (
        output seg_init, data_bptr, data_lptr, calc_busy,
        output smp_valid, smp_data,
        output coef_start, coef_ptr, coef_len,
        output coef_valid, coef_data,
        input  smp_ready, ram_we, ram_addr, ram_wdata,
        input  data_hptr, new_smp, buf_full, coef_done
    );

    modport slave (
        input  seg_init, data_bptr, data_lptr, calc_busy,
        input  smp_valid, smp_data,
        input  coef_start, coef_ptr, coef_len,
        input  coef_valid, coef_data,
        output smp_ready, ram_we, ram_addr, ram_wdata,
        output data_hptr, new_smp, buf_full, coef_done
    );

endinterface

// File: rtl/ctrl_ramwr_headptr.sv
// Ring-buffer head pointer and fill tracking.
// Wraps lptr->bptr, saturates fill at segment length.
module ctrl_ramwr_headptr
    import ctrl_ramwr_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  init,
    input  logic                  adv,
    input  logic [ADDR_WIDTH-1:0] data_bptr,
    input  logic [ADDR_WIDTH-1:0] data_lptr,
    output logic [ADDR_WIDTH-1:0] data_hptr,
    output logic                  buf_full
);

    localparam int FW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] head_nxt;
    logic [FW-1:0]         fill;
    logic [FW-1:0]         fill_nxt;
    logic [FW-1:0]         seg_len;

    // next head with wrap, segment length and saturated fill
    always_comb begin
        head_nxt = (data_hptr == data_lptr) ? data_bptr
                 : data_hptr + ADDR_WIDTH'(1);
        seg_len  = {1'b0, data_lptr} - {1'b0, data_bptr} + FW'(1);
        fill_nxt = (fill >= seg_len) ? fill : fill + FW'(1);
    end

    // head/fill state; clear beats init beats advance
    always_ff @(posedge clk) begin
        if (clr) begin
            data_hptr <= '0;
            fill      <= '0;
            buf_full  <= 1'b0;
        end else if (init) begin
            data_hptr <= data_lptr;
            fill      <= '0;
            buf_full  <= 1'b0;
        end else if (adv) begin
            data_hptr <= head_nxt;
            fill      <= fill_nxt;
            buf_full  <= (fill_nxt == seg_len);
        end
    end

endmodule

// File: rtl/ctrl_ramwr.sv
// RAM port A write driver.
// Ring-buffer sample writes and CPU coefficient loads.
module ctrl_ramwr
    import ctrl_ramwr_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    ctrl_ramwr_if.slave  bus
);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;
    logic [ADDR_WIDTH-1:0] rem;
    logic [ADDR_WIDTH-1:0] rem_nxt;
    logic                  we_q;
    logic                  we_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wdata_nxt;
    logic                  done_q;
    logic                  done_nxt;
    logic                  ns_d1;
    logic                  ns_q;
    logic                  ready;
    logic                  accept;
    logic                  init;
    logic [ADDR_WIDTH-1:0] hptr;
    logic                  full;
    logic [ADDR_WIDTH-1:0] head_nxt;

    // FSM next state, write port selection, handshake
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rem_nxt   = rem;
        we_nxt    = 1'b0;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        done_nxt  = 1'b0;
        ready     = 1'b0;
        accept    = 1'b0;
        init      = 1'b0;
        head_nxt  = (hptr == bus.data_lptr) ? bus.data_bptr
                  : hptr + ADDR_WIDTH'(1);
        unique case (state)
            CTRL_RAMWR_IDLE: begin
                ready  = ~rst & ~bus.calc_busy
                       & ~bus.seg_init & ~bus.coef_start;
                accept = ready & bus.smp_valid;
                init   = bus.seg_init;
                if (bus.coef_start) begin
                    cnt_nxt = bus.coef_ptr;
                    rem_nxt = bus.coef_len;
                    if (bus.coef_len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = CTRL_RAMWR_COEF;
                    end
                end
                if (accept) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = head_nxt;
                    wdata_nxt = bus.smp_data;
                end
            end
            CTRL_RAMWR_COEF: begin
                if (bus.coef_valid) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = cnt;
                    wdata_nxt = bus.coef_data;
                    cnt_nxt   = cnt + ADDR_WIDTH'(1);
                    rem_nxt   = rem - ADDR_WIDTH'(1);
                    if (rem == ADDR_WIDTH'(1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = CTRL_RAMWR_IDLE;
                    end
                end
            end
        endcase
    end

    // state, coefficient counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CTRL_RAMWR_IDLE;
            cnt     <= '0;
            rem     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            ns_d1   <= 1'b0;
            ns_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rem     <= rem_nxt;
            we_q    <= we_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            done_q  <= done_nxt;
            ns_d1   <= accept;
            ns_q    <= ns_d1;
        end
    end

    ctrl_ramwr_headptr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_headptr (
        .clk       (clk),
        .clr       (rst),
        .init      (init),
        .adv       (accept),
        .data_bptr (bus.data_bptr),
        .data_lptr (bus.data_lptr),
        .data_hptr (hptr),
        .buf_full  (full)
    );

    assign bus.smp_ready = ready;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.data_hptr = hptr;
    assign bus.new_smp   = ns_q;
    assign bus.buf_full  = full;
    assign bus.coef_done = done_q;

endmodule
